// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module  : uart_rx_frame
// Brief   : 8N1 UART receiver with mid-bit sampling and framing-error strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int BAUD_CNT_MAX = 433,
    parameter int HALF_CNT     = BAUD_CNT_MAX / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_flag_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam logic [15:0] BAUD_MAX_C = 16'(BAUD_CNT_MAX);
    localparam logic [15:0] HALF_C     = 16'(HALF_CNT);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_START = 4'b0010,
        ST_DATA  = 4'b0100,
        ST_STOP  = 4'b1000
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_flag_q, rx_flag_d;
    logic        frame_err_q, frame_err_d;
    logic        sync1_q, sync2_q, prev_q;
    logic        fall_edge;

    // Two-flop synchronizer plus one delay flop for edge detection; idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign fall_edge = prev_q & ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_flag_q   <= rx_flag_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_flag_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (fall_edge) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                baud_d = baud_q + 16'd1;
                if (baud_q == HALF_C) begin
                    // Line back high at the start-bit midpoint: treat as a glitch.
                    state_d = sync2_q ? ST_IDLE : ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_q == BAUD_MAX_C) begin
                    baud_d  = '0;
                    shreg_d = {sync2_q, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_MAX_C) begin
                    // Leaving mid-stop-bit lets a directly following start edge be caught.
                    state_d = ST_IDLE;
                    baud_d  = '0;
                    if (sync2_q) begin
                        rx_data_d = shreg_q;
                        rx_flag_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    assign rx_data_o   = rx_data_q;
    assign rx_flag_o   = rx_flag_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module  : tb_uart_rx_frame
// Brief   : Scoreboard bench for uart_rx_frame using a short bit period.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    localparam int BAUD   = 15;
    localparam int N      = BAUD + 1;
    localparam int HALF   = BAUD / 2;
    localparam int CLK_T  = 100;
    localparam int BIT_T  = N * CLK_T;
    localparam int BIT_FAST = (BIT_T * 97) / 100;
    localparam int BIT_SLOW = (BIT_T * 103) / 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       frame_err;
    logic       busy;

    always #(CLK_T / 2) clk = ~clk;

    uart_rx_frame #(
        .BAUD_CNT_MAX(BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx),
        .rx_data_o  (rx_data),
        .rx_flag_o  (rx_flag),
        .frame_err_o(frame_err),
        .busy_o     (busy)
    );

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_vec = 0;
    int         n_miss = 0;
    int         cyc = 0;
    int         last_pulse = -1;
    int         prev_pulse = -1;
    int         n_flags = 0;
    int         n_errs = 0;
    int         t_start = 0;
    logic [7:0] exp_last = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame; the expected outcome is queued before the start bit.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int bit_t);
        exp_t e;
        e.err  = ~stop;
        e.data = stop ? d : exp_last;
        if (stop) exp_last = d;
        sb_q.push_back(e);
        rx = 1'b0;
        #(bit_t);
        check("busy_in_frame", busy, 1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bit_t);
        end
        rx = stop;
        #(bit_t);
    endtask

    task automatic align();
        @(negedge clk);
        #1;
        t_start = cyc;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rx_flag || frame_err) begin
            check("flag_err_exclusive", {31'b0, rx_flag & frame_err}, 0);
            check("pulse_expected", {31'b0, sb_q.size() != 0}, 1);
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", {31'b0, frame_err}, {31'b0, mon_e.err});
                check("rx_data", {24'b0, rx_data}, {24'b0, mon_e.data});
            end
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (rx_flag) n_flags++;
            if (frame_err) n_errs++;
        end
    end

    initial begin
        #(20000 * CLK_T);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_data", {24'b0, rx_data}, 0);
        check("rst_rx_flag", {31'b0, rx_flag}, 0);
        check("rst_frame_err", {31'b0, frame_err}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame, with end-to-end latency from pin edge to strobe.
        align();
        send_byte(8'h55, 1'b1, BIT_T);
        repeat (4) @(negedge clk);
        check("latency_55", last_pulse - t_start, 4 + HALF + 9 * N);
        check("flags_after_55", n_flags, 1);
        check("busy_after_55", {31'b0, busy}, 0);

        // Back-to-back frames with no idle time.
        repeat (N) @(negedge clk);
        align();
        send_byte(8'hA5, 1'b1, BIT_T);
        send_byte(8'h3C, 1'b1, BIT_T);
        repeat (4) @(negedge clk);
        check("b2b_spacing", last_pulse - prev_pulse, 10 * N);
        check("flags_after_b2b", n_flags, 3);

        // Short low glitch must not start a frame.
        repeat (N) @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("glitch_flags", n_flags, 3);
        check("glitch_errs", n_errs, 0);
        check("glitch_rx_data", {24'b0, rx_data}, 32'h3C);
        check("glitch_busy", {31'b0, busy}, 0);

        // Stop bit forced low.
        align();
        send_byte(8'h81, 1'b0, BIT_T);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("ferr_errs", n_errs, 1);
        check("ferr_flags", n_flags, 3);
        check("ferr_rx_data", {24'b0, rx_data}, 32'h3C);

        // Reset in the middle of data bit 4 of 0xF0.
        align();
        rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(8'hF0 >> i);
            #(BIT_T);
        end
        rx = 1'b1;
        #(BIT_T / 2);
        rst_n = 1'b0;
        #(3 * CLK_T);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_rx_data", {24'b0, rx_data}, 0);
        exp_last = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * N) @(negedge clk);
        check("midrst_flags", n_flags, 3);
        align();
        send_byte(8'h0F, 1'b1, BIT_T);
        repeat (2 * N) @(negedge clk);
        check("after_rst_flags", n_flags, 4);
        check("after_rst_data", {24'b0, rx_data}, 32'h0F);

        // Baud mismatch of +3% and -3%.
        align();
        send_byte(8'hC3, 1'b1, BIT_SLOW);
        repeat (2 * N) @(negedge clk);
        align();
        send_byte(8'hC3, 1'b1, BIT_FAST);
        repeat (2 * N) @(negedge clk);
        check("skew_flags", n_flags, 6);
        check("skew_errs", n_errs, 1);

        // Break: line held low reports one framing error and does not retrigger.
        align();
        send_byte(8'h00, 1'b0, BIT_T);
        #(5 * BIT_T);
        check("break_errs", n_errs, 2);
        check("break_busy", {31'b0, busy}, 0);
        rx = 1'b1;
        repeat (3 * N) @(negedge clk);
        check("break_errs_after", n_errs, 2);
        check("break_flags", n_flags, 6);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
